// File: rtl/dsp_bb_pkg.sv
// Shared definitions for the DSP building blocks: divider FSM states and counter sizing.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package dsp_bb_pkg;

  // Divider control states. IDLE accepts work, CALC iterates, FIX finalises signs.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Width of an iteration counter that must hold the value awidth.
  function automatic int div_cnt_width(input int awidth);
    return $clog2(awidth + 1);
  endfunction

endpackage

// File: rtl/signed_divide_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
//
// Ports:
//   i_prem    current partial remainder (always < i_divisor for a nonzero divisor)
//   i_bit     next dividend bit shifted into the partial remainder
//   i_divisor divisor magnitude
//   o_prem    next partial remainder
//   o_qbit    quotient bit produced by this iteration
module signed_divide_step #(
  parameter int BWIDTH = 16
) (
  input  logic [BWIDTH-1:0] i_prem,
  input  logic              i_bit,
  input  logic [BWIDTH-1:0] i_divisor,
  output logic [BWIDTH-1:0] o_prem,
  output logic              o_qbit
);

  logic [BWIDTH:0] shifted;
  logic [BWIDTH:0] diff;

  // Since i_prem < i_divisor, shifted < 2*i_divisor, so one extra bit is
  // enough for the trial subtraction and its MSB is a clean borrow flag.
  always_comb begin
    shifted = {i_prem, i_bit};
    diff    = shifted - {1'b0, i_divisor};
    o_qbit  = ~diff[BWIDTH];
    o_prem  = o_qbit ? diff[BWIDTH-1:0] : shifted[BWIDTH-1:0];
  end

endmodule

// File: rtl/signed_divide.sv
// Sequential signed divider: quotient truncated toward zero, remainder takes the dividend's sign.
// Latency: o_valid in the cycle after edge k+AWIDTH+1 for a start accepted at edge k.
// Backpressure: none; i_start is only sampled while o_busy=0, otherwise dropped (no queue).
//
// Optional feature macro: SIGNED_DIVIDE_DBZ_EN -- zero divisor short-cuts IDLE->FIX and
// reports o_dbz=1 with zero quotient/remainder. Without it a zero divisor runs the full
// iteration count, o_quot/o_rem are meaningless and o_dbz stays 0.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 start request (accepted only when idle)
//   i_dividend, i_divisor   signed operands, sampled at acceptance only
//   o_busy                  high in CALC and FIX
//   o_valid                 one-cycle result strobe
//   o_quot (AWIDTH+1 bits)  signed quotient; extra bit makes MIN/-1 exact
//   o_rem                   signed remainder
//   o_dbz                   divide-by-zero flag, qualified by o_valid
module signed_divide
  import dsp_bb_pkg::*;
#(
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic signed [AWIDTH-1:0] i_dividend,
  input  logic signed [BWIDTH-1:0] i_divisor,
  output logic                     o_busy,
  output logic                     o_valid,
  output logic signed [AWIDTH:0]   o_quot,
  output logic signed [BWIDTH-1:0] o_rem,
  output logic                     o_dbz
);

  localparam int CW = div_cnt_width(AWIDTH);

  div_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // Dividend magnitude; quotient bits shift in at the bottom as dividend bits
  // leave the top, so after AWIDTH iterations it holds the quotient magnitude.
  logic [AWIDTH-1:0] dvd_q, dvd_d;
  logic [BWIDTH-1:0] dvs_q, dvs_d;
  logic [BWIDTH-1:0] prem_q, prem_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [AWIDTH:0]   quot_q, quot_d;
  logic [BWIDTH-1:0] rem_q, rem_d;
  logic              valid_q, valid_d;

  logic [AWIDTH-1:0] dvd_mag;
  logic [BWIDTH-1:0] dvs_mag;
  logic [AWIDTH:0]   quot_mag;
  logic [BWIDTH-1:0] step_prem;
  logic              step_qbit;

`ifdef SIGNED_DIVIDE_DBZ_EN
  logic dbz_pend_q, dbz_pend_d;
  logic dbz_q, dbz_d;
  logic dvs_zero;
  assign dvs_zero = (i_divisor == '0);
`endif

  // Magnitudes as unsigned values: negating the most negative operand
  // wraps to 2^(N-1), which is exactly the unsigned magnitude.
  always_comb begin
    dvd_mag = i_dividend;
    if (i_dividend[AWIDTH-1]) dvd_mag = -i_dividend;
    dvs_mag = i_divisor;
    if (i_divisor[BWIDTH-1]) dvs_mag = -i_divisor;
  end

  signed_divide_step #(
    .BWIDTH(BWIDTH)
  ) u_step (
    .i_prem   (prem_q),
    .i_bit    (dvd_q[AWIDTH-1]),
    .i_divisor(dvs_q),
    .o_prem   (step_prem),
    .o_qbit   (step_qbit)
  );

  assign quot_mag = {1'b0, dvd_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
`ifdef SIGNED_DIVIDE_DBZ_EN
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          dvd_d   = dvd_mag;
          dvs_d   = dvs_mag;
          prem_d  = '0;
          qneg_d  = i_dividend[AWIDTH-1] ^ i_divisor[BWIDTH-1];
          rneg_d  = i_dividend[AWIDTH-1];
          cnt_d   = CW'(AWIDTH);
          state_d = ST_CALC;
`ifdef SIGNED_DIVIDE_DBZ_EN
          dbz_pend_d = dvs_zero;
          if (dvs_zero) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end
`endif
        end
      end

      ST_CALC: begin
        prem_d = step_prem;
        dvd_d  = {dvd_q[AWIDTH-2:0], step_qbit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        quot_d  = qneg_q ? -quot_mag : quot_mag;
        rem_d   = rneg_q ? -prem_q : prem_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
`ifdef SIGNED_DIVIDE_DBZ_EN
        dbz_d = dbz_pend_q;
        if (dbz_pend_q) begin
          quot_d = '0;
          rem_d  = '0;
        end
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

`ifdef SIGNED_DIVIDE_DBZ_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
    end
  end
  assign o_dbz = dbz_q;
`else
  assign o_dbz = 1'b0;
`endif

  assign o_busy  = (state_q != ST_IDLE);
  assign o_valid = valid_q;
  assign o_quot  = quot_q;
  assign o_rem   = rem_q;

endmodule
